// File: rtl/ray_dispatcher_pkg.sv
// Shared types for the ray dispatcher: camera vector type and dispatcher states.
package ray_dispatcher_pkg;
   localparam int VEC3_BITS = 48;

   typedef logic [VEC3_BITS-1:0] vec3;

   typedef enum logic [1:0] {DS_Idle, DS_Issue, DS_Drain} dispatch_state_t;

   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/ray_dispatcher_rr.sv
// Round-robin arbiter: grants the lowest requester above the last grant, else wraps to the lowest.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] last,
   output logic [N-1:0] grant
);
   logic [N-1:0] mask;
   logic [N-1:0] req_hi;

   always_comb begin
      // last is one-hot (or zero after reset); mask keeps only the bits strictly above it
      mask   = ~((last << 1) - N'(1));
      req_hi = req & mask;
      if (req_hi != '0) grant = req_hi & (~req_hi + N'(1));
      else              grant = req & (~req + N'(1));
   end
endmodule

// File: rtl/ray_dispatcher.sv
// Walks a frame in raster order, issues pixels to idle ray_units round-robin and
// serializes their finished shades into the framebuffer, one write per cycle.
module ray_dispatcher
   import ray_dispatcher_pkg::*;
#(
   parameter int NUM_UNITS      = 4,
   parameter int DISPLAY_WIDTH  = 320,
   parameter int DISPLAY_HEIGHT = 180,
   parameter int H_BITS         = $clog2(DISPLAY_WIDTH),
   parameter int V_BITS         = $clog2(DISPLAY_HEIGHT),
   parameter int ADDR_BITS      = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          start_in,
   input  logic [VEC3_BITS-1:0]          ray_origin_in,
   input  logic [VEC3_BITS-1:0]          cam_forward_in,
   output logic [NUM_UNITS-1:0]          ru_valid_out,
   output logic [H_BITS-1:0]             ru_hcount_out,
   output logic [V_BITS-1:0]             ru_vcount_out,
   output logic [VEC3_BITS-1:0]          ru_origin_out,
   output logic [VEC3_BITS-1:0]          ru_direction_out,
   input  logic [NUM_UNITS-1:0]          ru_ready_in,
   input  logic [NUM_UNITS*H_BITS-1:0]   ru_hcount_in,
   input  logic [NUM_UNITS*V_BITS-1:0]   ru_vcount_in,
   input  logic [NUM_UNITS*4-1:0]        ru_color_in,
   output logic                          fb_we_out,
   output logic [ADDR_BITS-1:0]          fb_addr_out,
   output logic [3:0]                    fb_data_out,
   output logic                          busy_out,
   output logic                          frame_done_out
);
   localparam int IW = idx_bits(NUM_UNITS);

   dispatch_state_t state, state_next;

   logic [NUM_UNITS-1:0] pending, inflight, result, last_grant;
   logic [NUM_UNITS-1:0] eligible, issue_req, grant, wsel;
   logic [H_BITS-1:0]    h_cnt;
   logic [V_BITS-1:0]    v_cnt;
   logic [IW-1:0]        widx;
   logic [H_BITS-1:0]    wh;
   logic [V_BITS-1:0]    wv;
   logic                 last_pixel, all_clear;

   assign eligible   = ru_ready_in & ~pending & ~inflight & ~result;
   assign issue_req  = (state == DS_Issue) ? eligible : '0;
   assign last_pixel = (h_cnt == H_BITS'(DISPLAY_WIDTH - 1)) && (v_cnt == V_BITS'(DISPLAY_HEIGHT - 1));
   assign all_clear  = ~|(pending | inflight | result);
   assign busy_out   = (state != DS_Idle);

   rr_arbiter #(.N(NUM_UNITS)) u_arb (
      .req   (issue_req),
      .last  (last_grant),
      .grant (grant)
   );

   always_comb begin
      state_next = state;
      case (state)
         DS_Idle:  if (start_in) state_next = DS_Issue;
         DS_Issue: if ((|grant) && last_pixel) state_next = DS_Drain;
         DS_Drain: if (all_clear) state_next = DS_Idle;
         default:  state_next = DS_Idle;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= DS_Idle;
      else        state <= state_next;
   end

   // Lowest-index finished unit wins the write port
   always_comb begin
      wsel = '0;
      widx = '0;
      for (int i = NUM_UNITS - 1; i >= 0; i--) begin
         if (result[i]) begin
            wsel    = '0;
            wsel[i] = 1'b1;
            widx    = IW'(i);
         end
      end
      wh = ru_hcount_in[widx*H_BITS +: H_BITS];
      wv = ru_vcount_in[widx*V_BITS +: V_BITS];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pending          <= '0;
         inflight         <= '0;
         result           <= '0;
         last_grant       <= '0;
         h_cnt            <= '0;
         v_cnt            <= '0;
         ru_valid_out     <= '0;
         ru_hcount_out    <= '0;
         ru_vcount_out    <= '0;
         ru_origin_out    <= '0;
         ru_direction_out <= '0;
         fb_we_out        <= 1'b0;
         fb_addr_out      <= '0;
         fb_data_out      <= '0;
         frame_done_out   <= 1'b0;
      end else begin
         ru_valid_out   <= '0;
         fb_we_out      <= 1'b0;
         frame_done_out <= 1'b0;

         // Ready must be seen low before a high ready counts as completion
         pending  <= (pending & ru_ready_in) | grant;
         inflight <= (inflight | pending) & ~ru_ready_in;
         result   <= (result | (inflight & ru_ready_in)) & ~wsel;

         if (state == DS_Idle && start_in) begin
            ru_origin_out    <= ray_origin_in;
            ru_direction_out <= cam_forward_in;
            h_cnt            <= '0;
            v_cnt            <= '0;
         end

         if (|grant) begin
            ru_valid_out  <= grant;
            ru_hcount_out <= h_cnt;
            ru_vcount_out <= v_cnt;
            last_grant    <= grant;
            if (h_cnt == H_BITS'(DISPLAY_WIDTH - 1)) begin
               h_cnt <= '0;
               v_cnt <= v_cnt + V_BITS'(1);
            end else begin
               h_cnt <= h_cnt + H_BITS'(1);
            end
         end

         if (|result) begin
            fb_we_out   <= 1'b1;
            fb_addr_out <= ADDR_BITS'(int'(wv) * DISPLAY_WIDTH + int'(wh));
            fb_data_out <= ru_color_in[widx*4 +: 4];
         end

         if (state == DS_Drain && all_clear) frame_done_out <= 1'b1;
      end
   end
endmodule
